// File: rtl/m90_pkg.sv
// Shared types and helpers for the m90 palette stage: palette word layout,
// 5->8 bit colour expansion and the CPU access state machine encoding.
package m90_pkg;

  localparam int unsigned AddrW = 11;

  typedef struct packed {
    logic       unused;
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } pal_word_t;

  typedef enum logic [1:0] {StIdle, StPend, StAcc, StCap} cpu_state_t;

  // Replicate the top bits so 5'h1f maps to full-scale 8'hff.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

endpackage

// File: rtl/m90_palette_if.sv
// CPU palette bus: select/strobes, address, byte enables and data, plus the
// busy handshake returned by the palette.
interface m90_palette_if;
  import m90_pkg::*;

  logic             mem_cs;
  logic             mem_rd;
  logic             mem_wr;
  logic [AddrW-1:0] addr;
  logic [1:0]       cpu_be;
  logic [15:0]      cpu_din;
  logic [15:0]      cpu_dout;
  logic             busy;

  modport master (
    output mem_cs, mem_rd, mem_wr, addr, cpu_be, cpu_din,
    input  cpu_dout, busy
  );

  modport slave (
    input  mem_cs, mem_rd, mem_wr, addr, cpu_be, cpu_din,
    output cpu_dout, busy
  );

endinterface

// File: rtl/m90_pal_cpu_if.sv
// CPU side of the palette: strobe edge detect, request latch and the access
// FSM that borrows the RAM on the non-pixel ce phase.
module m90_pal_cpu_if
    import m90_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             ce_pix,
    m90_palette_if.slave     bus,
    input  logic [15:0]      ram_q,
    output logic [AddrW-1:0] ram_addr,
    output logic [1:0]       ram_we,
    output logic [15:0]      ram_din,
    output logic             grant
);

    cpu_state_t       state_q, state_d;
    logic             req, req_q, rise;
    logic [AddrW-1:0] addr_q;
    logic [15:0]      din_q, dout_q;
    logic [1:0]       be_q;
    logic             wr_q, busy_q;

    assign req  = bus.mem_cs & (bus.mem_rd | bus.mem_wr);
    assign rise = req & ~req_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (rise) state_d = StPend;
            StPend:  if (ce & ~ce_pix) state_d = StAcc;
            StAcc:   state_d = StCap;
            StCap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The CPU slot is the ce pulse without ce_pix, so it never collides with video.
    assign grant    = (state_q == StPend) & ce & ~ce_pix;
    assign ram_we   = {2{grant & wr_q}} & be_q;
    assign ram_addr = addr_q;
    assign ram_din  = din_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req;
            busy_q  <= (state_d != StIdle);
            if (state_q == StIdle && rise) begin
                addr_q <= bus.addr;
                din_q  <= bus.cpu_din;
                be_q   <= bus.cpu_be;
                wr_q   <= bus.mem_wr;
            end
            if (state_q == StAcc && !wr_q) begin
                dout_q <= ram_q;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.cpu_dout = dout_q;

endmodule

// File: rtl/singleport_ram.sv
// Generic single-port synchronous RAM: registered read, write-first not
// guaranteed (read returns the previous contents on a same-address write).
module singleport_ram #(
    parameter int widthad_a = 11,
    parameter int width_a   = 8
) (
    input  logic                 clock,
    input  logic [widthad_a-1:0] address,
    input  logic [width_a-1:0]   data,
    input  logic                 wren,
    output logic [width_a-1:0]   q
);

    logic [width_a-1:0] mem [2**widthad_a];

    always_ff @(posedge clock) begin
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

endmodule

// File: rtl/m90_palette.sv
// Palette lookup stage: 11-bit mixer index -> 2048x16 RAM -> 8-bit RGB, with
// the timing signals delayed to stay aligned. CPU shares the RAM on alternate ce.
module m90_palette
    import m90_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             ce_pix,
    m90_palette_if.slave     bus,
    input  logic [AddrW-1:0] color_in,
    input  logic             hblank_in,
    input  logic             vblank_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             hblank,
    output logic             vblank,
    output logic             hsync,
    output logic             vsync
);

    logic             vid_phase, vid_phase_q, cpu_grant;
    logic [AddrW-1:0] cpu_addr, ram_addr;
    logic [1:0]       ram_we;
    logic [15:0]      ram_din, ram_q;
    pal_word_t        vid_q;
    logic             s1_hblank, s1_vblank, s1_hsync, s1_vsync;
    logic             vid_unused;

    assign vid_phase  = ce & ce_pix;
    assign ram_addr   = cpu_grant ? cpu_addr : color_in;
    assign vid_unused = vid_q.unused;

    m90_pal_cpu_if u_cpu (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .ce_pix   (ce_pix),
        .bus      (bus),
        .ram_q    (ram_q),
        .ram_addr (cpu_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .grant    (cpu_grant)
    );

    singleport_ram #(.widthad_a(AddrW), .width_a(8)) u_ram_lo (
        .clock   (clk),
        .address (ram_addr),
        .data    (ram_din[7:0]),
        .wren    (ram_we[0]),
        .q       (ram_q[7:0])
    );

    singleport_ram #(.widthad_a(AddrW), .width_a(8)) u_ram_hi (
        .clock   (clk),
        .address (ram_addr),
        .data    (ram_din[15:8]),
        .wren    (ram_we[1]),
        .q       (ram_q[15:8])
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_phase_q <= 1'b0;
            vid_q       <= '0;
            s1_hblank   <= 1'b1;
            s1_vblank   <= 1'b1;
            s1_hsync    <= 1'b0;
            s1_vsync    <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
        end else begin
            vid_phase_q <= vid_phase;
            // RAM q is valid the clk after the video address was presented.
            if (vid_phase_q) begin
                vid_q <= pal_word_t'(ram_q);
            end
            if (vid_phase) begin
                if (s1_hblank | s1_vblank) begin
                    red   <= '0;
                    green <= '0;
                    blue  <= '0;
                end else begin
                    red   <= expand5(vid_q.r);
                    green <= expand5(vid_q.g);
                    blue  <= expand5(vid_q.b);
                end
                hblank    <= s1_hblank;
                vblank    <= s1_vblank;
                hsync     <= s1_hsync;
                vsync     <= s1_vsync;
                s1_hblank <= hblank_in;
                s1_vblank <= vblank_in;
                s1_hsync  <= hsync_in;
                s1_vsync  <= vsync_in;
            end
        end
    end

endmodule
